// File: rtl/fpmul_norm_round.sv
// Normalize / round-to-nearest-even / pack stage of the binary32 multiplier.
// Two-stage valid/ready pipeline with backpressure and a sticky exception-flag register.
module fpmul_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_prod,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic [1:0]  in_class,
    input  logic        in_invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    input  logic        clr_flags,
    output logic [3:0]  sticky_flags
);
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    logic        load1, load2, xfer;
    logic        v1_q, v2_q;
    logic [22:0] m1_q, m1_d;
    logic        g1_q, g1_d, s1_q, s1_d;
    logic [10:0] e1_q, e1_d;
    logic        sign1_q, inv1_q;
    logic [1:0]  cls1_q;
    logic [31:0] res_q, res_d;
    logic [3:0]  flg_q, flg_d;
    logic [3:0]  sticky_q, sticky_d;
    logic [23:0] mr;
    logic [10:0] e2;
    logic        rnd, inexact;

    assign load2    = !v2_q | out_ready;
    assign load1    = !v1_q | load2;
    assign in_ready = load1;
    assign xfer     = v2_q & out_ready;

    // Stage 1: pick the leading one position, split into mantissa/guard/sticky.
    always_comb begin
        e1_d = {in_exp[9], in_exp} + {10'd0, in_prod[47]};
        if (in_prod[47]) begin
            m1_d = in_prod[46:24];
            g1_d = in_prod[23];
            s1_d = |in_prod[22:0];
        end else begin
            m1_d = in_prod[45:23];
            g1_d = in_prod[22];
            s1_d = |in_prod[21:0];
        end
    end

    // Stage 2: a rounding carry-out leaves mr[22:0] zero and bumps the exponent.
    always_comb begin
        rnd     = g1_q & (s1_q | m1_q[0]);
        mr      = {1'b0, m1_q} + {23'd0, rnd};
        e2      = e1_q + {10'd0, mr[23]};
        inexact = g1_q | s1_q;
        res_d   = {sign1_q, e2[7:0], mr[22:0]};
        flg_d   = {inv1_q, 2'b00, inexact};
        case (cls1_q)
            CLS_NAN:  begin res_d = 32'h7FC0_0000;           flg_d = {inv1_q, 3'b000}; end
            CLS_INF:  begin res_d = {sign1_q, 8'hFF, 23'h0}; flg_d = {inv1_q, 3'b000}; end
            CLS_ZERO: begin res_d = {sign1_q, 31'h0};        flg_d = {inv1_q, 3'b000}; end
            default: begin
                if ($signed(e2) >= 11'sd255) begin
                    res_d = {sign1_q, 8'hFF, 23'h0};
                    flg_d = {inv1_q, 3'b101};
                end else if ($signed(e2) <= 11'sd0) begin
                    res_d = {sign1_q, 31'h0};
                    flg_d = {inv1_q, 3'b011};
                end
            end
        endcase
    end

    // A clear coinciding with a transfer keeps only that transfer's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_flags)
            sticky_d = xfer ? flg_q : 4'h0;
        else if (xfer)
            sticky_d = sticky_q | flg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            m1_q    <= '0;
            g1_q    <= 1'b0;
            s1_q    <= 1'b0;
            e1_q    <= '0;
            sign1_q <= 1'b0;
            cls1_q  <= '0;
            inv1_q  <= 1'b0;
        end else if (load1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                m1_q    <= m1_d;
                g1_q    <= g1_d;
                s1_q    <= s1_d;
                e1_q    <= e1_d;
                sign1_q <= in_sign;
                cls1_q  <= in_class;
                inv1_q  <= in_invalid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            res_q    <= '0;
            flg_q    <= '0;
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            if (load2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    res_q <= res_d;
                    flg_q <= flg_d;
                end
            end
        end
    end

    assign out_valid    = v2_q;
    assign out_result   = res_q;
    assign out_flags    = flg_q;
    assign sticky_flags = sticky_q;
endmodule

// File: tb/tb_fpmul_norm_round.sv
// Bench for fpmul_norm_round: directed vector table, backpressure / sticky / reset
// sequences and randomized traffic against an integer-arithmetic rounding model.
module tb_fpmul_norm_round;
    typedef struct {
        logic [47:0] prod;
        logic [9:0]  ex;
        logic        sign;
        logic [1:0]  cls;
        logic        inv;
        logic [31:0] eres;
        logic [3:0]  eflg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [47:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic [1:0]  in_class;
    logic        in_invalid;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        clr_flags;
    logic [3:0]  sticky_flags;

    int   checks = 0;
    int   failures = 0;
    vec_t q[$];
    logic [3:0] sticky_m;
    logic s_in_ready;

    fpmul_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign),
        .in_class(in_class), .in_invalid(in_invalid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: treat the product as an integer, divide out 2^k and round the remainder.
    function automatic vec_t mk(input logic [47:0] p, input logic [9:0] ex, input logic sg,
                                input logic [1:0] cls, input logic inv);
        vec_t v;
        longint P, qm, r, half;
        int k, e;
        logic [63:0] qb;
        logic inx;
        v.prod = p; v.ex = ex; v.sign = sg; v.cls = cls; v.inv = inv;
        v.eflg = {inv, 3'b000};
        if (cls == 2'b11) v.eres = 32'h7FC0_0000;
        else if (cls == 2'b10) v.eres = {sg, 8'hFF, 23'h0};
        else if (cls == 2'b01) v.eres = {sg, 31'h0};
        else begin
            P    = longint'(p);
            k    = (P >= (longint'(1) << 47)) ? 24 : 23;
            e    = int'($signed(ex)) + k - 23;
            qm   = P >> k;
            r    = P - (qm << k);
            half = longint'(1) << (k - 1);
            inx  = (r != 0);
            if (r > half || (r == half && (qm % 2) == 1)) qm++;
            if (qm == (longint'(1) << 24)) begin
                qm = longint'(1) << 23;
                e++;
            end
            qb = qm;
            if (e >= 255) begin
                v.eres = {sg, 8'hFF, 23'h0};
                v.eflg = {inv, 3'b101};
            end else if (e <= 0) begin
                v.eres = {sg, 31'h0};
                v.eflg = {inv, 3'b011};
            end else begin
                v.eres = {sg, 8'(e), qb[22:0]};
                v.eflg = {inv, 2'b00, inx};
            end
        end
        return v;
    endfunction

    function automatic vec_t rand_vec();
        logic [63:0] r;
        int t;
        logic [9:0] ex;
        logic [1:0] cls;
        r = {$urandom, $urandom};
        if (r[47:46] == 2'b00) r[46] = 1'b1;
        case ($urandom % 4)
            0: r[21:0] = '0;
            1: r[22:0] = '0;
            default: ;
        endcase
        t   = int'($urandom_range(300, 0)) - 20;
        ex  = t[9:0];
        cls = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
        return mk(r[47:0], ex, 1'($urandom), cls, ($urandom % 8) == 0);
    endfunction

    // One cycle: drive after the falling edge, sample and score 1 time unit later.
    task automatic step(input logic v, input vec_t b, input logic rdy, input logic clr,
                        output logic acc, output logic took);
        vec_t f;
        f = '{default: 0};
        @(negedge clk);
        in_valid = v; in_prod = b.prod; in_exp = b.ex; in_sign = b.sign;
        in_class = b.cls; in_invalid = b.inv; out_ready = rdy; clr_flags = clr;
        #1;
        s_in_ready = in_ready;
        acc  = in_valid & in_ready;
        took = out_valid & out_ready;
        chk("sticky_model", 32'(sticky_flags), 32'(sticky_m));
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h with nothing pending", out_result);
            end else begin
                f = q[0];
                chk("result", out_result, f.eres);
                chk("flags", 32'(out_flags), 32'(f.eflg));
                if (took) void'(q.pop_front());
            end
        end
        if (clr) sticky_m = took ? f.eflg : 4'h0;
        else if (took) sticky_m = sticky_m | f.eflg;
        if (acc) q.push_back(b);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        vec_t bp[4];
        vec_t idle, cur;
        logic acc, took;
        int k;

        idle = '{default: 0};
        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_exp = '0; in_sign = 1'b0;
        in_class = '0; in_invalid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        sticky_m = 4'h0;

        tbl[0]  = '{48'h9000_0000_0000, 10'd127, 1'b0, 2'd0, 1'b0, 32'h4010_0000, 4'b0000};
        tbl[1]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'd0, 1'b0, 32'h3F80_0002, 4'b0001};
        tbl[2]  = '{48'h4000_0040_0000, 10'd127, 1'b0, 2'd0, 1'b0, 32'h3F80_0000, 4'b0001};
        tbl[3]  = '{48'h8000_0000_0000, 10'd254, 1'b0, 2'd0, 1'b0, 32'h7F80_0000, 4'b0101};
        tbl[4]  = '{48'h4000_0000_0000, 10'd0,   1'b0, 2'd0, 1'b0, 32'h0000_0000, 4'b0011};
        tbl[5]  = '{48'h4000_0000_0000, 10'd0,   1'b0, 2'd3, 1'b1, 32'h7FC0_0000, 4'b1000};
        tbl[6]  = '{48'h4000_0000_0000, 10'd0,   1'b1, 2'd2, 1'b0, 32'hFF80_0000, 4'b0000};
        tbl[7]  = '{48'h4000_0000_0000, 10'd50,  1'b1, 2'd1, 1'b0, 32'h8000_0000, 4'b0000};
        tbl[8]  = '{48'h7FFF_FFC0_0000, 10'd127, 1'b0, 2'd0, 1'b0, 32'h4000_0000, 4'b0001};
        tbl[9]  = '{48'h4000_0000_0000, 10'h3FB, 1'b1, 2'd0, 1'b0, 32'h8000_0000, 4'b0011};
        tbl[10] = '{48'h8000_0000_0000, 10'd253, 1'b0, 2'd0, 1'b0, 32'h7F00_0000, 4'b0000};
        tbl[11] = '{48'h4000_0000_0000, 10'd1,   1'b0, 2'd0, 1'b0, 32'h0080_0000, 4'b0000};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: result visible on the second cycle after the beat is driven.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i], 1'b1, 1'b0, acc, took);
            chk("tbl_accept", 32'(acc), 32'd1);
            step(1'b0, tbl[i], 1'b1, 1'b0, acc, took);
            chk("tbl_not_early", 32'(took), 32'd0);
            step(1'b0, tbl[i], 1'b1, 1'b0, acc, took);
            chk("tbl_latency", 32'(took), 32'd1);
        end

        // Sticky: clear, then overflow, then clear concurrent with an inexact-only transfer.
        step(1'b0, idle, 1'b1, 1'b1, acc, took);
        step(1'b0, idle, 1'b1, 1'b0, acc, took);
        chk("sticky_cleared", 32'(sticky_flags), 32'd0);
        step(1'b1, tbl[3], 1'b1, 1'b0, acc, took);
        repeat (3) step(1'b0, idle, 1'b1, 1'b0, acc, took);
        chk("sticky_overflow", 32'(sticky_flags), 32'b0101);
        step(1'b1, tbl[1], 1'b1, 1'b0, acc, took);
        step(1'b0, idle, 1'b1, 1'b0, acc, took);
        step(1'b0, idle, 1'b1, 1'b1, acc, took);
        chk("clr_with_xfer_took", 32'(took), 32'd1);
        step(1'b0, idle, 1'b1, 1'b0, acc, took);
        chk("sticky_clr_xfer", 32'(sticky_flags), 32'b0001);

        // Backpressure: 4 back-to-back beats, consumer stalled for the first 3 cycles.
        for (int i = 0; i < 4; i++) bp[i] = rand_vec();
        k = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            step(k < 4, bp[(k < 4) ? k : 3], cyc >= 3, 1'b0, acc, took);
            if (cyc == 2) chk("bp_in_ready_low", 32'(s_in_ready), 32'd0);
            if (acc) k++;
        end
        chk("bp_all_accepted", k, 32'd4);
        chk("bp_drained", q.size(), 32'd0);

        // Randomized traffic with random stalls and clears.
        cur = rand_vec();
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 10) < 7, cur, ($urandom % 10) < 7, ($urandom % 20) == 0, acc, took);
            if (acc) cur = rand_vec();
        end
        for (int g = 0; g < 20 && q.size() > 0; g++)
            step(1'b0, cur, 1'b1, 1'b0, acc, took);
        chk("random_drained", q.size(), 32'd0);

        // Reset with two beats in flight: everything discarded, nothing emerges later.
        step(1'b1, tbl[3], 1'b0, 1'b0, acc, took);
        step(1'b1, tbl[1], 1'b0, 1'b0, acc, took);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sticky", 32'(sticky_flags), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        q.delete();
        sticky_m = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, idle, 1'b1, 1'b0, acc, took);
            chk("post_rst_no_output", 32'(took), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
